// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter: takes one N-bit word over valid/ready and shifts it
// out on cs_n/sclk/sdo, one word per chip-select frame, then pulses o_done.
module spi_word_tx #(
    parameter int N         = 32,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_data,
    input  logic         i_valid,
    output logic         i_ready,
    output logic         busy,
    output logic         o_done,
    output logic         cs_n,
    output logic         sclk,
    output logic         sdo
);

    localparam int BIT_W = $clog2(N + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    if (N < 1 || CLK_DIV < 1) begin : g_param_check
        $error("spi_word_tx: N and CLK_DIV must both be >= 1");
    end

    state_e             state_q, state_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               sdo_q, sdo_d;
    logic               o_done_q, o_done_d;
    logic [N-1:0]       shreg_shift_s;

    // Bit that goes on the wire first for a given shift-register content.
    function automatic logic lead_bit(input logic [N-1:0] w);
        if (MSB_FIRST) begin
            lead_bit = w[N-1];
        end else begin
            lead_bit = w[0];
        end
    endfunction

    assign i_ready = (state_q == ST_IDLE) & rst;
    assign busy    = (state_q != ST_IDLE);
    assign o_done  = o_done_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign sdo     = sdo_q;

    // Shift register advanced by one bit in the transmit direction.
    always_comb begin
        shreg_shift_s = shreg_q;
        if (MSB_FIRST) begin
            shreg_shift_s = shreg_q << 1'b1;
        end else begin
            shreg_shift_s = shreg_q >> 1'b1;
        end
    end

    // Next-state and output logic of the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        o_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                if (i_valid && i_ready) begin
                    shreg_d   = i_data;
                    cs_n_d    = 1'b0;
                    sdo_d     = lead_bit(i_data);
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    // Only the falling sclk edge moves data; rising is the sample point.
                    if (sclk_q) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d  = ST_DONE;
                            sdo_d    = 1'b0;
                            cs_n_d   = 1'b1;
                            o_done_d = 1'b1;
                        end else begin
                            shreg_d = shreg_shift_s;
                            sdo_d   = lead_bit(shreg_shift_s);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                sdo_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                sdo_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            o_done_q  <= o_done_d;
        end
    end

endmodule

// File: tb/tb_spi_word_tx.sv
// Bench for spi_word_tx: an MSB-first and an LSB-first instance share all inputs and
// are checked frame by frame against a per-bit reference of the SPI word.
module tb_spi_word_tx;

    localparam int PERIOD = 10;

    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic [1:0] rdy, bsy, done, csn, sck, sdo;

    int    n_checks;
    int    n_errors;
    longint t_acc;
    longint t_last;
    bit    prev_hold;

    spi_word_tx #(.N(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .i_ready(rdy[0]), .busy(bsy[0]), .o_done(done[0]),
        .cs_n(csn[0]), .sclk(sck[0]), .sdo(sdo[0])
    );

    spi_word_tx #(.N(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .i_ready(rdy[1]), .busy(bsy[1]), .o_done(done[1]),
        .cs_n(csn[1]), .sclk(sck[1]), .sdo(sdo[1])
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Bit idx (0 = first on the wire) of word w for the chosen order.
    function automatic logic exp_bit(input logic [7:0] w, input int idx, input bit msb);
        if (msb) return w[7 - idx];
        return w[idx];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_csn"}, 32'(csn), 32'd3);
        check({tag, "_sclk"}, 32'(sck), 32'd0);
        check({tag, "_sdo"}, 32'(sdo), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(bsy), 32'd0);
        check({tag, "_ready"}, 32'(rdy), 32'd0);
    endtask

    // Called shortly after a negedge; drops reset mid-clock and releases it later.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b0;
        #1 check_idle(tag);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_no_done"}, 32'(done), 32'd0);
            check({tag, "_held"}, 32'(csn), 32'd3);
        end
        rst = 1'b1;
        #1 check({tag, "_ready_after"}, 32'(rdy), 32'd3);
        prev_hold = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] word, input bit hold, input bit poke);
        int rises [2];
        int low [2];
        int dones [2];
        logic [1:0] prev_sck;
        int w;
        i_data  = word;
        i_valid = 1'b1;
        w = 0;
        while (rdy !== 2'b11 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", 32'(rdy), 32'd3);
        @(posedge clk);
        t_acc = $time;
        if (prev_hold) check("accept_period", 32'((t_acc - t_last) / PERIOD), 32'd34);
        t_last    = t_acc;
        prev_hold = hold;
        #1;
        i_data = 8'($urandom);
        if (!hold) i_valid = 1'b0;
        prev_sck = 2'b00;
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0;
            low[d]   = 0;
            dones[d] = 0;
        end
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (poke && k == 10) begin
                i_data  = 8'h00;
                i_valid = 1'b1;
            end
            if (poke && k == 14) i_valid = hold;
            check("busy", 32'(bsy), (k <= 33) ? 32'd3 : 32'd0);
            check("ready", 32'(rdy), (k == 34) ? 32'd3 : 32'd0);
            for (int d = 0; d < 2; d++) begin
                if (sck[d] && !prev_sck[d]) begin
                    if (rises[d] < 8) begin
                        if (d == 0) check("sdo_msb", 32'(sdo[d]), 32'(exp_bit(word, rises[d], 1'b1)));
                        else        check("sdo_lsb", 32'(sdo[d]), 32'(exp_bit(word, rises[d], 1'b0)));
                    end
                    rises[d]++;
                end
                if (!csn[d]) low[d]++;
                if (done[d]) begin
                    dones[d]++;
                    check("done_cycle", 32'(k), 32'd33);
                end
            end
            prev_sck = sck;
        end
        for (int d = 0; d < 2; d++) begin
            check("rising_edges", 32'(rises[d]), 32'd8);
            check("cs_low_cycles", 32'(low[d]), 32'd32);
            check("done_pulses", 32'(dones[d]), 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nr;
        int w;
        logic prev;
        logic [7:0] word;
        bit hold;
        bit poke;
        n_checks  = 0;
        n_errors  = 0;
        prev_hold = 1'b0;
        t_last    = 0;
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_data    = 8'h00;

        // Reset asserted mid-clock, then release.
        repeat (2) @(negedge clk);
        reset_pulse("reset");

        // Directed frames: ordering, back-to-back acceptance, input isolation.
        @(negedge clk);
        run_frame(8'h1E, 1'b0, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0);
        run_frame(8'h00, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b0, 1'b1);

        // Abort a frame of C3 after three rising sclk edges.
        i_data  = 8'hC3;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        nr   = 0;
        w    = 0;
        prev = 1'b0;
        while (nr < 3 && w < 40) begin
            @(negedge clk);
            if (sck[0] && !prev) nr++;
            prev = sck[0];
            w++;
        end
        check("rises_before_abort", 32'(nr), 32'd3);
        reset_pulse("abort");
        run_frame(8'h3C, 1'b0, 1'b0);

        // Randomized traffic with held valid, idle gaps and mid-frame pokes.
        for (int i = 0; i < 20; i++) begin
            word = 8'($urandom);
            hold = (i < 19) && ($urandom_range(0, 1) == 1);
            poke = !hold && ($urandom_range(0, 3) == 0);
            run_frame(word, hold, poke);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
